uart_frame_parser: RTL and testbench

- Downstream consumer of the UART receiver's byte stream (data[7:0] and single-cycle data_valid).
- Extracts framed packets of the form SYNC, LEN, PAYLOAD[LEN], CSUM.
- Checks length and checksum, stores the payload in a small internal buffer and exposes it through a read port.
- Sits between the UART receiver and the board-level display/command logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 21 ++
 rtl/uart_frame_parser.sv | 169 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_pkg;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hAA;
  localparam int unsigned MAX_LEN_DEF   = 16;
  localparam int unsigned CPLD_CLK_HZ   = 66_000_000;
  localparam int unsigned BAUD_BPS      = 9600;

  // Idle limit of two 10-bit characters: (clk / baud) * 20 bit times.
  localparam int unsigned TIMEOUT_CLKS_DEF = (CPLD_CLK_HZ / BAUD_BPS) * 20;

  localparam int unsigned IDLE_CNT_W = 18;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one synchronous write port, asynchronous read port.
module uart_frame_buf #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(MAX_LEN)-1:0] waddr,
  input  logic [7:0]                 wdata,
  input  logic [$clog2(MAX_LEN)-1:0] raddr,
  output logic [7:0]                 rdata
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SYNC/LEN/PAYLOAD/CSUM frames from the UART byte stream.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int unsigned MAX_LEN      = MAX_LEN_DEF,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data,
  input  logic                         data_valid,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  output logic                         frame_valid,
  output logic                         frame_done,
  output logic                         err_csum,
  output logic                         err_len,
  output logic                         err_timeout
);

  localparam int unsigned AW        = $clog2(MAX_LEN);
  localparam int unsigned LW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  if (TIMEOUT_CLKS < 2 || TIMEOUT_CLKS > (2 ** IDLE_CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CLKS does not fit the idle counter");
  end

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [LW-1:0]   frame_len_q, frame_len_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            err_csum_q, err_csum_d;
  logic            err_len_q, err_len_d;
  logic            buf_we;
  logic            timeout_c;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [IDLE_CNT_W-1:0] idle_q, idle_d;
  logic                  err_timeout_q;

  // Idle counter only runs while a frame is open; any byte restarts it.
  always_comb begin
    timeout_c = (state_q != HUNT) && !data_valid &&
                (idle_q == IDLE_CNT_W'(TIMEOUT_CLKS - 1));
    if (state_q == HUNT || data_valid || timeout_c) idle_d = '0;
    else                                            idle_d = idle_q + IDLE_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      idle_q        <= idle_d;
      err_timeout_q <= timeout_c;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign timeout_c   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Frame FSM: consumes one byte per data_valid; timeout only fires without a byte.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    err_csum_d    = 1'b0;
    err_len_d     = 1'b0;
    buf_we        = 1'b0;
    if (timeout_c) begin
      state_d = HUNT;
    end else if (data_valid) begin
      unique case (state_q)
        HUNT: begin
          if (data == SYNC_BYTE) state_d = LEN;
        end
        LEN: begin
          if (data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = HUNT;
          end else if (data == 8'h00) begin
            len_d   = '0;
            sum_d   = 8'h00;
            state_d = CSUM;
          end else begin
            len_d   = LW'(data);
            sum_d   = data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          buf_we = 1'b1;
          sum_d  = sum_q + data;
          idx_d  = idx_q + AW'(1);
          if (idx_q == '0) frame_valid_d = 1'b0;
          if (LW'(idx_q) == len_q - LW'(1)) state_d = CSUM;
        end
        CSUM: begin
          if (data == sum_q) begin
            frame_len_d   = len_q;
            frame_valid_d = 1'b1;
            frame_done_d  = 1'b1;
          end else begin
            err_csum_d = 1'b1;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      len_q         <= '0;
      idx_q         <= '0;
      sum_q         <= 8'h00;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      err_csum_q    <= err_csum_d;
      err_len_q     <= err_len_d;
    end
  end

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign err_csum    = err_csum_q;
  assign err_len     = err_len_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a queue-based frame model.
module tb_uart_frame_parser;

  localparam int MAXL = 16;
  localparam int TO   = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       data_valid;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] frame_len;
  logic       frame_valid, frame_done, err_csum, err_len, err_timeout;

  uart_frame_parser #(
    .SYNC_BYTE    (8'hAA),
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .data_valid  (data_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .err_csum    (err_csum),
    .err_len     (err_len),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;
  int n_done = 0, n_ecs = 0, n_elen = 0, n_eto = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect bytes after SYNC, judge a frame once LEN + payload + csum are in.
  bit         in_frame = 1'b0;
  logic [7:0] cur[$];
  logic [7:0] mbuf[MAXL];
  int         exp_fl = 0;
  bit         exp_fv = 1'b0;
  bit         exp_done = 1'b0, exp_ecs = 1'b0, exp_elen = 1'b0, exp_eto = 1'b0;
  int         idle = 0;

  always @(posedge clk) begin
    int s;
    exp_done = 1'b0; exp_ecs = 1'b0; exp_elen = 1'b0; exp_eto = 1'b0;
    if (rst) begin
      in_frame = 1'b0; cur.delete(); exp_fl = 0; exp_fv = 1'b0; idle = 0;
    end else if (data_valid) begin
      idle = 0;
      if (!in_frame) begin
        if (data == 8'hAA) begin in_frame = 1'b1; cur.delete(); end
      end else begin
        cur.push_back(data);
        if (cur.size() == 1 && int'(cur[0]) > MAXL) begin
          exp_elen = 1'b1; in_frame = 1'b0;
        end else if (cur.size() >= 2 && cur.size() == int'(cur[0]) + 2) begin
          s = 0;
          for (int i = 0; i < cur.size() - 1; i++) s += int'(cur[i]);
          if ((s % 256) == int'(data)) begin
            exp_done = 1'b1; exp_fl = int'(cur[0]); exp_fv = 1'b1;
          end else begin
            exp_ecs = 1'b1;
          end
          in_frame = 1'b0;
        end else if (cur.size() >= 2) begin
          mbuf[cur.size() - 2] = data;
          if (cur.size() == 2) exp_fv = 1'b0;
        end
      end
    end
`ifdef UART_FRAME_TIMEOUT_EN
    else if (in_frame) begin
      idle++;
      if (idle == TO) begin exp_eto = 1'b1; in_frame = 1'b0; idle = 0; end
    end
`endif
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("err_csum", 32'(err_csum), 32'(exp_ecs));
      chk("err_len", 32'(err_len), 32'(exp_elen));
      chk("err_timeout", 32'(err_timeout), 32'(exp_eto));
      chk("frame_len", 32'(frame_len), 32'(exp_fl));
      chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
      n_done += int'(frame_done);
      n_ecs  += int'(err_csum);
      n_elen += int'(err_len);
      n_eto  += int'(err_timeout);
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    @(negedge clk);
    data = b; data_valid = 1'b1;
    if (gap) begin @(negedge clk); data_valid = 1'b0; end
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin @(negedge clk); data_valid = 1'b0; end
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] lit);
    @(negedge clk);
    rd_addr = a;
    #1;
    chk("rd_data_lit", 32'(rd_data), 32'(lit));
    chk("rd_data_model", 32'(rd_data), 32'(mbuf[a]));
  endtask

  initial begin
    int d_done, d_ecs, d_elen, d_eto;
    rst = 1'b1; data = 8'h00; data_valid = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    chk("reset_frame_len", 32'(frame_len), 32'd0);
    chk("reset_frame_valid", 32'(frame_valid), 32'd0);

    // Good frame: 03+11+22+33 = 69
    d_done = n_done;
    send(8'hAA, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h69, 1);
    idle_cyc(3);
    chk("t1_done_cnt", 32'(n_done - d_done), 32'd1);
    chk("t1_len", 32'(frame_len), 32'd3);
    chk("t1_valid", 32'(frame_valid), 32'd1);
    rd_chk(4'd0, 8'h11); rd_chk(4'd1, 8'h22); rd_chk(4'd2, 8'h33);

    // Checksum error, then zero-length good frame
    d_done = n_done; d_ecs = n_ecs;
    send(8'hAA, 1); send(8'h02, 1); send(8'h10, 1); send(8'h20, 1); send(8'h31, 1);
    idle_cyc(3);
    chk("t2_csum_cnt", 32'(n_ecs - d_ecs), 32'd1);
    chk("t2_no_done", 32'(n_done - d_done), 32'd0);
    chk("t2_valid", 32'(frame_valid), 32'd0);
    send(8'hAA, 1); send(8'h00, 1); send(8'h00, 1);
    idle_cyc(3);
    chk("t2_zero_done", 32'(n_done - d_done), 32'd1);
    chk("t2_zero_len", 32'(frame_len), 32'd0);
    chk("t2_zero_valid", 32'(frame_valid), 32'd1);

    // Oversize LEN, then in-frame AA treated as data
    d_elen = n_elen; d_done = n_done;
    send(8'h55, 1); send(8'hAA, 1); send(8'h11, 1);
    idle_cyc(3);
    chk("t3_len_err", 32'(n_elen - d_elen), 32'd1);
    send(8'h00, 1); send(8'hAA, 1); send(8'h01, 1); send(8'hAA, 1); send(8'hAB, 1);
    idle_cyc(3);
    chk("t3_done", 32'(n_done - d_done), 32'd1);
    chk("t3_len", 32'(frame_len), 32'd1);
    rd_chk(4'd0, 8'hAA);

    // Back-to-back strobes with sum wrap: 02+FF+02 = 103 -> 03
    d_done = n_done;
    send(8'hAA, 0); send(8'h02, 0); send(8'hFF, 0); send(8'h02, 0); send(8'h03, 0);
    idle_cyc(3);
    chk("t4_done", 32'(n_done - d_done), 32'd1);
    chk("t4_len", 32'(frame_len), 32'd2);
    rd_chk(4'd0, 8'hFF); rd_chk(4'd1, 8'h02);

    // Maximum length frame, payload 0..15, sum 10+78 = 88
    d_done = n_done;
    send(8'hAA, 0); send(8'h10, 0);
    for (int k = 0; k < 16; k++) send(8'(k), 0);
    send(8'h88, 0);
    idle_cyc(3);
    chk("t_max_done", 32'(n_done - d_done), 32'd1);
    chk("t_max_len", 32'(frame_len), 32'd16);
    rd_chk(4'd15, 8'h0F); rd_chk(4'd7, 8'h07);

    // Reset mid-frame: no pulses, then a normal frame
    d_done = n_done; d_ecs = n_ecs; d_elen = n_elen;
    send(8'hAA, 1); send(8'h04, 1); send(8'h01, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    idle_cyc(2);
    chk("t5_no_pulse", 32'((n_done - d_done) + (n_ecs - d_ecs) + (n_elen - d_elen)), 32'd0);
    chk("t5_len_rst", 32'(frame_len), 32'd0);
    send(8'hAA, 1); send(8'h01, 1); send(8'h55, 1); send(8'h56, 1);
    idle_cyc(3);
    chk("t5_done", 32'(n_done - d_done), 32'd1);
    chk("t5_len", 32'(frame_len), 32'd1);
    rd_chk(4'd0, 8'h55);

`ifdef UART_FRAME_TIMEOUT_EN
    // 99-cycle gaps survive; a 100-cycle gap times out once
    d_done = n_done; d_eto = n_eto;
    send(8'hAA, 0); send(8'h02, 0); send(8'h01, 0);
    idle_cyc(99); send(8'h02, 0);
    idle_cyc(99); send(8'h05, 0);
    idle_cyc(3);
    chk("t6_gap_done", 32'(n_done - d_done), 32'd1);
    chk("t6_gap_no_to", 32'(n_eto - d_eto), 32'd0);
    send(8'hAA, 0); send(8'h02, 0); send(8'h01, 0);
    idle_cyc(100);
    idle_cyc(3);
    chk("t6_timeout_cnt", 32'(n_eto - d_eto), 32'd1);
    chk("t6_valid_cleared", 32'(frame_valid), 32'd0);
    d_done = n_done;
    send(8'hAA, 1); send(8'h00, 1); send(8'h00, 1);
    idle_cyc(3);
    chk("t6_hunt_after_to", 32'(n_done - d_done), 32'd1);
`else
    chk("no_timeout_pulse", 32'(n_eto), 32'd0);
`endif

    idle_cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
